// File: rtl/mc_controller.sv
// Multicycle main controller for the MIPS-subset datapath.
// Moore outputs are registered; handshake/flag-gated strobes are combinational.
module mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       done;
  } moore_t;

  state_t state;
  state_t nxt;
  state_t dec_nxt;
  moore_t mo;

  logic is_lw, is_sw, is_r;
  logic is_beq, is_addi, is_j;
  logic is_legal;

  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_r     = (op == 6'b000000);
  assign is_beq   = (op == 6'b000100);
  assign is_addi  = (op == 6'b001000);
  assign is_j     = (op == 6'b000010);
  assign is_legal = is_lw | is_sw | is_r
                  | is_beq | is_addi | is_j;

  always_comb begin
    dec_nxt = FETCH;
    unique case (1'b1)
      is_lw, is_sw: dec_nxt = MEMADR;
      is_r:         dec_nxt = EXEC;
      is_beq:       dec_nxt = BRANCH;
      is_addi:      dec_nxt = ADDIEX;
      is_j:         dec_nxt = JUMP;
      default:      dec_nxt = FETCH;
    endcase
  end

  always_comb begin
    nxt = FETCH;
    unique case (state)
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE:  nxt = dec_nxt;
      MEMADR:  nxt = is_lw ? MEMRD : MEMWR;
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
      EXEC:    nxt = ALUWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  function automatic moore_t moore(state_t s);
    moore_t m;
    m = '0;
    unique case (s)
      FETCH: begin
        m.mem_read = 1'b1;
        m.alusrcb  = 2'b01;
      end
      DECODE: m.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        m.alusrca = 1'b1;
        m.alusrcb = 2'b10;
      end
      MEMRD: begin
        m.mem_read = 1'b1;
        m.iord     = 1'b1;
      end
      MEMWB: begin
        m.regwrite = 1'b1;
        m.memtoreg = 1'b1;
        m.done     = 1'b1;
      end
      MEMWR: begin
        m.mem_write = 1'b1;
        m.iord      = 1'b1;
      end
      EXEC: begin
        m.alusrca = 1'b1;
        m.aluop   = 2'b10;
      end
      ALUWB: begin
        m.regwrite = 1'b1;
        m.regdst   = 1'b1;
        m.done     = 1'b1;
      end
      BRANCH: begin
        m.alusrca = 1'b1;
        m.aluop   = 2'b01;
        m.pcsrc   = 2'b01;
        m.done    = 1'b1;
      end
      ADDIWB: begin
        m.regwrite = 1'b1;
        m.done     = 1'b1;
      end
      JUMP: begin
        m.pcsrc = 2'b10;
        m.pcen  = 1'b1;
        m.done  = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  // Outputs are precomputed from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      mo    <= moore(FETCH);
    end else begin
      state <= nxt;
      mo    <= moore(nxt);
    end
  end

  assign mem_read  = mo.mem_read;
  assign mem_write = mo.mem_write;
  assign iord      = mo.iord;
  assign regdst    = mo.regdst;
  assign memtoreg  = mo.memtoreg;
  assign regwrite  = mo.regwrite;
  assign alusrca   = mo.alusrca;
  assign alusrcb   = mo.alusrcb;
  assign aluop     = mo.aluop;
  assign pcsrc     = mo.pcsrc;

  assign irwrite    = (state == FETCH) & mem_ready;
  assign illegal_op = (state == DECODE) & ~is_legal;
  assign pcen       = mo.pcen
                    | ((state == FETCH) & mem_ready)
                    | ((state == BRANCH) & zero);
  assign instr_done = mo.done | illegal_op
                    | ((state == MEMWR) & mem_ready);
  assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction vectors scored via a queue,
// plus cycle-exact sequences and an asynchronous reset case.
module tb_mc_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, instr_done, illegal_op;
  logic [3:0] state_dbg;

  mc_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         fw;
    int         mw;
    int         cyc;
    int         rw;
    int         pc;
    int         mr;
    int         mwr;
    int         ill;
    int         dstate;
    int         dpcsrc;
    int         dpcen;
  } vec_t;

  vec_t vt[9];
  vec_t sb[$];
  int   es[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic rdy(int c, int fw, int mw);
    return !((c < fw) || (c >= fw + 3 && c < fw + 3 + mw));
  endfunction

  task automatic run_instr(input vec_t v);
    vec_t e;
    int   c, rw, pc, mr, mwr, ill, bad, irw;
    int   ds, dpcs, dpce;
    bit   done;
    sb.push_back(v);
    rw = 0; pc = 0; mr = 0; mwr = 0; ill = 0;
    bad = 0; irw = 0; done = 0;
    ds = 0; dpcs = 0; dpce = 0;
    c = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      op        = v.op;
      zero      = v.zero;
      mem_ready = rdy(c, v.fw, v.mw);
      #1;
      rw  += int'(regwrite);
      pc  += int'(pcen);
      mr  += int'(mem_read);
      mwr += int'(mem_write);
      ill += int'(illegal_op);
      irw += int'(irwrite);
      if (mem_read && mem_write) bad++;
      if (regwrite && (state_dbg == 3 || state_dbg == 5)) bad++;
      c++;
      if (instr_done) begin
        done = 1;
        ds   = int'(state_dbg);
        dpcs = int'(pcsrc);
        dpce = int'(pcen);
      end
    end
    e = sb.pop_front();
    if (!done) begin
      chk($sformatf("timeout_op%0h", e.op), c, e.cyc);
    end else begin
      chk($sformatf("cycles_op%0h", e.op), c, e.cyc);
      chk($sformatf("regwrite_op%0h", e.op), rw, e.rw);
      chk($sformatf("pcen_op%0h", e.op), pc, e.pc);
      chk($sformatf("memread_op%0h", e.op), mr, e.mr);
      chk($sformatf("memwrite_op%0h", e.op), mwr, e.mwr);
      chk($sformatf("illegal_op%0h", e.op), ill, e.ill);
      chk($sformatf("irwrite_op%0h", e.op), irw, 1);
      chk($sformatf("donestate_op%0h", e.op), ds, e.dstate);
      chk($sformatf("donepcsrc_op%0h", e.op), dpcs, e.dpcsrc);
      chk($sformatf("donepcen_op%0h", e.op), dpce, e.dpcen);
      chk($sformatf("conflict_op%0h", e.op), bad, 0);
    end
  endtask

  task automatic seq(input logic [5:0] o, input int mw, input int n);
    int dn;
    dn = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op        = o;
      zero      = 1'b0;
      mem_ready = rdy(i, 0, mw);
      #1;
      chk($sformatf("seq%0h_state%0d", o, i), int'(state_dbg), es[i]);
      dn += int'(instr_done);
      if (es[i] == 6) chk("exec_aluop", int'(aluop), 2);
      if (es[i] == 7) chk("aluwb_rw_rd", int'({regwrite, regdst}), 3);
      if (es[i] == 3) chk("memrd_rd_iord", int'({mem_read, iord}), 3);
      if (es[i] == 4) chk("memwb_mtr_rw", int'({memtoreg, regwrite}), 3);
    end
    chk($sformatf("seq%0h_done", o), dn, 1);
  endtask

  initial begin
    vt[0] = '{6'h00, 1'b0, 0, 0, 4, 1, 1, 1, 0, 0, 7, 0, 0};
    vt[1] = '{6'h23, 1'b0, 0, 2, 7, 1, 1, 4, 0, 0, 4, 0, 0};
    vt[2] = '{6'h2b, 1'b0, 1, 1, 6, 0, 1, 2, 2, 0, 5, 0, 0};
    vt[3] = '{6'h04, 1'b1, 0, 0, 3, 0, 2, 1, 0, 0, 8, 1, 1};
    vt[4] = '{6'h04, 1'b0, 3, 0, 6, 0, 1, 4, 0, 0, 8, 1, 0};
    vt[5] = '{6'h08, 1'b0, 0, 0, 4, 1, 1, 1, 0, 0, 10, 0, 0};
    vt[6] = '{6'h02, 1'b0, 2, 0, 5, 0, 2, 3, 0, 0, 11, 2, 1};
    vt[7] = '{6'h3f, 1'b0, 0, 0, 2, 0, 1, 1, 0, 1, 1, 0, 0};
    vt[8] = '{6'h23, 1'b0, 0, 0, 5, 1, 1, 2, 0, 0, 4, 0, 0};

    reset_n   = 1'b0;
    op        = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #12;
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_memread", int'(mem_read), 1);
    chk("rst_alusrcb", int'(alusrcb), 1);
    chk("rst_others", int'({mem_write, iord, irwrite, regdst, memtoreg,
                            regwrite, alusrca, aluop, pcsrc, pcen,
                            instr_done, illegal_op}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    es = '{0, 1, 6, 7, 0, 0, 0, 0};
    seq(6'h00, 0, 4);
    es = '{0, 1, 2, 3, 3, 3, 4, 0};
    seq(6'h23, 2, 7);

    for (int i = 0; i < 9; i++) run_instr(vt[i]);

    // abandon a store while it waits on memory
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      op        = 6'h2b;
      mem_ready = (c < 3);
      #1;
    end
    chk("memwr_state", int'(state_dbg), 5);
    chk("memwr_write", int'(mem_write), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", int'(state_dbg), 0);
    chk("arst_memwrite", int'(mem_write), 0);
    chk("arst_memread", int'(mem_read), 1);
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_instr(vt[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle main controller for the MIPS-subset datapath.
- Sequences fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one unified memory port.
- Drives the 2-bit aluop consumed by the ALU decoder: 00 = add, 01 = sub, 10 = use funct.
- Stretches memory states until the memory handshake completes.

Parameters:
- STATE_W, 4, width of state register and state_dbg port.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- op  input  6  opcode field from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- iord  output  1  address mux: 0 = PC, 1 = ALUOut
- irwrite  output  1  instruction register load
- regdst  output  1  write register: 0 = rt, 1 = rd
- memtoreg  output  1  writeback source: 0 = ALUOut, 1 = MDR
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A: 0 = PC, 1 = regA
- alusrcb  output  2  ALU B: 00 = regB, 01 = const 4, 10 = signimm, 11 = signimm<<2
- aluop  output  2  to ALU decoder
- pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  output  1  PC write enable
- instr_done  output  1  one-cycle pulse on the last cycle of every instruction
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- state_dbg  output  STATE_W  current state encoding

Behaviour:
- Async reset (reset_n = 0) sets state to FETCH immediately. Each output then takes its FETCH value: mem_read = 1, alusrcb = 01, all others 0.
- Reset mid-instruction abandons the instruction. Write enables drop combinationally.
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Encodings 12–15 go to FETCH on the next clock.
- Outputs are Moore except where marked (g), meaning ANDed with mem_ready.
- Unlisted outputs are 0 in each state.
- FETCH:
  - mem_read = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - irwrite and pcen = mem_ready (g).
  - Stay in FETCH while mem_ready = 0, else go to DECODE.
- DECODE: alusrca = 0, alusrcb = 11, aluop = 00. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other op -> FETCH, with illegal_op = 1 and instr_done = 1.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. Go to MEMRD if op = lw, else MEMWR.
- MEMRD:
  - mem_read = 1, iord = 1.
  - Hold while mem_ready = 0, else go to MEMWB.
  - The MDR captures data every cycle; MEMWB uses the value from the mem_ready cycle.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0, instr_done = 1. Go to FETCH.
- MEMWR:
  - mem_write = 1, iord = 1.
  - Hold while mem_ready = 0. instr_done = mem_ready (g). Go to FETCH on mem_ready.
- EXEC: alusrca = 1, alusrcb = 00, aluop = 10. Go to ALUWB.
- ALUWB: regwrite = 1, regdst = 1, memtoreg = 0, instr_done = 1. Go to FETCH.
- BRANCH:
  - alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01.
  - pcen = zero (combinational), instr_done = 1. Go to FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00. Go to ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0, instr_done = 1. Go to FETCH.
- JUMP: pcsrc = 10, pcen = 1, instr_done = 1. Go to FETCH.
- Cycle counts with mem_ready always 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
- Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_read and mem_write are never both 1. regwrite is never 1 in a memory state.
- op is sampled only in DECODE and MEMADR; the datapath holds the IR stable.

Test Plan:
- Reset, then release with mem_ready = 1 and op = 000000: states 0,1,6,7,0. aluop = 10 in EXEC; regwrite = 1 and regdst = 1 in ALUWB; instr_done pulses once.
- lw (op = 100011) with mem_ready low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. mem_read = 1, iord = 1 throughout MEMRD; memtoreg = 1 and regwrite = 1 in MEMWB.
- beq (op = 000100): with zero = 1, pcen = 1, pcsrc = 01, aluop = 01 in BRANCH. Repeat with zero = 0: pcen = 0; both take 3 cycles.
- FETCH with mem_ready = 0 for 3 cycles: irwrite = 0 and pcen = 0 while waiting. Single irwrite/pcen pulse on the mem_ready cycle.
- Illegal op = 111111: illegal_op and instr_done pulse in DECODE; next state FETCH. j (op = 000010): pcen = 1, pcsrc = 10.
- Assert reset_n = 0 asynchronously during MEMWR: state_dbg = 0 and mem_write = 0 before the next clock edge. After release, fetch restarts.
